bounce_gen: RTL
===============

Name: bounce_gen

Overview:
- Synthesizable mechanical-switch bounce emulator: the transmit side of the switch line that the debouncer receives.
- Converts a clean `level_i` into a bouncy `sw_o`. `sw_o` toggles at pseudo-random intervals for a fixed bounce window, then settles to the target level.
- Uses: drive the debouncer on FPGA demo boards and in directed/SVA benches, back-to-back (`sw_o` → debouncer `sw_i`).

Parameters:
- ClkFreq, 100_000_000: clock frequency in Hz.
- BounceUs, 5000: bounce window in microseconds.
  - BounceCycles = ClkFreq/1_000_000*BounceUs.
  - Elaboration error if BounceCycles < 2.
- GlitchBits, 4: toggle interval = `lfsr[GlitchBits-1:0]`+1 cycles, i.e. 1..2**GlitchBits. Legal range 1..8.
- Seed, 16'hACE1: LFSR reset value. Elaboration error if 0.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- en_i  in  1  1 = bounce on level change; 0 = pass-through
- level_i  in  1  clean target switch level
- sw_o  out  1  emulated bouncy switch output (registered)
- busy_o  out  1  high while in BOUNCE
- done_tick_o  out  1  one-cycle pulse when the window ends
- bounce_cnt_o  out  8  toggles in the current/last window, saturating at 255

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, sw_o=0, target_q=0, busy_o=0, done_tick_o=0, bounce_cnt_o=0.
  - lfsr=Seed, counters=0.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Steps only when an interval is loaded.
- States: IDLE, BOUNCE. All outputs are registered and update one cycle after the edge that decides them.
- IDLE, en_i=0:
  - sw_o<=level_i, target_q<=level_i (1-cycle delay, no bounce).
  - No done_tick_o, bounce_cnt_o unchanged.
- IDLE, en_i=1, level_i!=target_q, at edge E0:
  - state<=BOUNCE, target_q<=level_i, sw_o<=~sw_o, bounce_cnt_o<=1.
  - win_cnt<=BounceCycles-1, ivl_cnt<=`lfsr[GlitchBits-1:0]`; LFSR steps.
- IDLE, en_i=1, level_i==target_q: hold.
- BOUNCE, per edge, in priority order:
  1. Retarget, if level_i!=target_q:
     - target_q<=level_i, win_cnt<=BounceCycles-1.
     - Interval logic still runs this cycle.
  2. Window end, else if win_cnt==0:
     - sw_o<=target_q, state<=IDLE, done_tick_o<=1.
     - No toggle this cycle.
  3. Otherwise:
     - win_cnt--.
     - If ivl_cnt==0: sw_o toggles, bounce_cnt_o increments (saturating), ivl_cnt reloads from the LFSR, LFSR steps.
     - Else ivl_cnt--.
- Timing of a window:
  - busy_o is high for exactly BounceCycles cycles after E0 with no retarget.
  - sw_o is final at E0+BounceCycles; done_tick_o is high during that same cycle.
- Interval bounds: consecutive sw_o toggles inside a window are 1..2**GlitchBits cycles apart.
- Retarget back to the original level: still bounces; sw_o ends at the original level and done_tick_o still fires.
- en_i falling during BOUNCE: ignored; the window completes normally.
- Reset mid-BOUNCE: immediate return to reset values; the LFSR restarts from Seed (deterministic replay).
- win_cnt width = $clog2(BounceCycles); ivl_cnt width = GlitchBits.

Decomposition:
- config_pkg:
  - `bounce_state_e` {IDLE, BOUNCE}.
  - LFSR width/taps constants.
  - Bench defaults for ClkFreq/BounceUs.
- Sub-module `lfsr`: parameterised Seed; ports clk_i, rst_ni, step_i, value_o[15:0].
- bounce_gen holds the FSM and counters.

Test Plan (ClkFreq=1_000_000, BounceUs=100 → 100 cycles, GlitchBits=3, Seed default):
- Reset mid-operation:
  - Stimulus: pulse rst_ni low for 3 cycles while busy_o=1.
  - Response: sw_o=0, busy_o=0, bounce_cnt_o=0 asynchronously.
  - Repeat the stimulus after reset: sw_o trace is identical to the first run.
- Rising level:
  - Stimulus: en_i=1, level_i 0→1.
  - Response: sw_o toggles one cycle after E0; busy_o high exactly 100 cycles; done_tick_o single pulse at E0+100; sw_o=1 held; every toggle gap in 1..8; bounce_cnt_o equals the number of sw_o edges counted by the bench.
- Retarget:
  - Stimulus: level_i 0→1, then 1→0 at E0+40.
  - Response: busy_o ends at E0+40+100; final sw_o=0; exactly one done_tick_o.
- Pass-through:
  - Stimulus: en_i=0, toggle level_i every 5 cycles.
  - Response: sw_o = level_i delayed 1 cycle, zero bounce, busy_o=0, no done_tick_o.
- Disable during bounce:
  - Stimulus: en_i drops at E0+10.
  - Response: window still runs to E0+100; done_tick_o fires.
- Back-to-back with debouncer (StableTime > 8 cycles):
  - Response: db_level_o changes exactly once per level_i change; one db_tick_o per rising settle.

Source files
------------

// File: rtl/bounce_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bounce_gen_pkg
// Description : Shared types and constants for the switch-bounce emulator.
//               Holds the FSM state type, the LFSR geometry and tap mask, the
//               LFSR next-state helper and the reduced-size bench defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package bounce_gen_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } bounce_state_e;

    localparam int c_LFSR_WIDTH = 16;

    // Right-shifting Fibonacci register: feedback is the XOR of bits 0,2,3,5,
    // which realises x^16 + x^14 + x^13 + x^11 + 1. The result enters at bit 15.
    localparam logic [c_LFSR_WIDTH-1:0] c_LFSR_TAPS = 16'h002D;

    // Small window used by simulation benches: 1 MHz * 100 us = 100 cycles.
    localparam int c_TB_CLK_FREQ  = 1_000_000;
    localparam int c_TB_BOUNCE_US = 100;

    function automatic logic [c_LFSR_WIDTH-1:0] lfsr_next(input logic [c_LFSR_WIDTH-1:0] v);
        return {^(v & c_LFSR_TAPS), v[c_LFSR_WIDTH-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bounce_gen_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : bounce_gen_lfsr
// Description : 16-bit Fibonacci LFSR that advances only when asked to.
//               Supplies the pseudo-random toggle intervals of bounce_gen.
// Ports       : clk_i   - system clock
//               rst_ni  - asynchronous active-low reset (loads SEED)
//               step_i  - advance the register by one step this cycle
//               value_o - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_gen_lfsr
    import bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        step_i,
    output logic [15:0] value_o
);

    logic [c_LFSR_WIDTH-1:0] r_state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SEED;
        end else if (step_i) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign value_o = r_state;

endmodule
`default_nettype wire

// File: rtl/bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : bounce_gen
// Description : Mechanical-switch bounce emulator. A change of the clean
//               level_i makes sw_o toggle at pseudo-random 1..2**GLITCH_BITS
//               cycle intervals for a fixed window, then settle to the level.
// Ports       : clk_i        - system clock
//               rst_ni       - asynchronous active-low reset
//               en_i         - 1: bounce on level change, 0: pass-through
//               level_i      - clean target switch level
//               sw_o         - emulated bouncy switch output (registered)
//               busy_o       - high while a bounce window is running
//               done_tick_o  - one-cycle pulse when the window ends
//               bounce_cnt_o - toggles in current/last window, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int          CLK_FREQ    = 100_000_000,
    parameter int          BOUNCE_US   = 5000,
    parameter int          GLITCH_BITS = 4,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       level_i,
    output logic       sw_o,
    output logic       busy_o,
    output logic       done_tick_o,
    output logic [7:0] bounce_cnt_o
);

    localparam int c_BOUNCE_CYCLES = CLK_FREQ / 1_000_000 * BOUNCE_US;
    localparam int c_WIN_W         = (c_BOUNCE_CYCLES > 1) ? $clog2(c_BOUNCE_CYCLES) : 1;

    localparam logic [c_WIN_W-1:0]     c_WIN_RELOAD = c_WIN_W'(c_BOUNCE_CYCLES - 1);
    localparam logic [c_WIN_W-1:0]     c_WIN_ONE    = c_WIN_W'(1);
    localparam logic [GLITCH_BITS-1:0] c_IVL_ONE    = GLITCH_BITS'(1);

    generate
        if (c_BOUNCE_CYCLES < 2) begin : g_chk_cycles
            $error("bounce_gen: bounce window must span at least 2 clock cycles");
        end
        if (GLITCH_BITS < 1 || GLITCH_BITS > 8) begin : g_chk_glitch
            $error("bounce_gen: GLITCH_BITS must be in 1..8");
        end
        if (SEED == 16'h0000) begin : g_chk_seed
            $error("bounce_gen: an all-zero LFSR seed locks up the generator");
        end
    endgenerate

    bounce_state_e          r_state;
    logic                   r_sw;
    logic                   r_target;
    logic                   r_done;
    logic [7:0]             r_cnt;
    logic [c_WIN_W-1:0]     r_win;
    logic [GLITCH_BITS-1:0] r_ivl;

    logic [15:0]            w_lfsr;
    logic                   w_start;
    logic                   w_retarget;
    logic                   w_run_ivl;
    logic                   w_step;
    logic                   w_lfsr_unused;

    // Only the low GLITCH_BITS of the LFSR feed the interval counter.
    assign w_lfsr_unused = ^w_lfsr;

    assign w_start    = (r_state == IDLE) && en_i && (level_i != r_target);
    assign w_retarget = (r_state == BOUNCE) && (level_i != r_target);
    // The interval counter runs on every BOUNCE cycle except the one that
    // closes the window; a retarget keeps it running.
    assign w_run_ivl  = (r_state == BOUNCE) && (w_retarget || (r_win != '0));
    // The LFSR advances exactly when a fresh interval is loaded.
    assign w_step     = w_start || (w_run_ivl && (r_ivl == '0));

    bounce_gen_lfsr #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .step_i  (w_step),
        .value_o (w_lfsr)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_sw     <= 1'b0;
            r_target <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= 8'd0;
            r_win    <= '0;
            r_ivl    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!en_i) begin
                        r_sw     <= level_i;
                        r_target <= level_i;
                    end else if (w_start) begin
                        r_state  <= BOUNCE;
                        r_target <= level_i;
                        r_sw     <= ~r_sw;
                        r_cnt    <= 8'd1;
                        r_win    <= c_WIN_RELOAD;
                        r_ivl    <= w_lfsr[GLITCH_BITS-1:0];
                    end
                end
                BOUNCE: begin
                    if (w_retarget) begin
                        r_target <= level_i;
                        r_win    <= c_WIN_RELOAD;
                    end else if (r_win == '0) begin
                        r_sw    <= r_target;
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_win <= r_win - c_WIN_ONE;
                    end

                    if (w_run_ivl) begin
                        if (r_ivl == '0) begin
                            r_sw  <= ~r_sw;
                            r_ivl <= w_lfsr[GLITCH_BITS-1:0];
                            if (r_cnt != 8'hFF) begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end else begin
                            r_ivl <= r_ivl - c_IVL_ONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sw_o         = r_sw;
    assign busy_o       = (r_state == BOUNCE);
    assign done_tick_o  = r_done;
    assign bounce_cnt_o = r_cnt;

endmodule
`default_nettype wire
